// File: rtl/adc_serial_capture.sv
// adc_serial_capture: shared csn/sclk serial ADC capture engine.
// Shifts NCH data lines in parallel; one result word per frame.
module adc_serial_capture #(
  parameter int NCH        = 2,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2,
  parameter int QUIET_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [NCH-1:0]        ADC_sdata,
  output logic                  ADC_sclk,
  output logic                  ADC_csn,
  output logic [NCH*DATA_W-1:0] data,
  output logic                  data_valid,
  output logic [NCH-1:0]        frame_err,
  output logic                  busy
);

  localparam int HALVES = 2 * FRAME_BITS + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(HALVES);
  localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALVES - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    QUIET
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] div;
  logic [HW-1:0] half;
  logic [QW-1:0] qcnt;
  logic [NCH-1:0][FRAME_BITS-1:0] shreg;
  logic [NCH-1:0] lead;
  logic half_end, rise, frame_end, quiet_end;

  // Odd half-periods are sclk-low; their last edge is the rising edge.
  assign half_end  = (state == CONVERT) && (div == DIV_LAST);
  assign rise      = half_end && half[0];
  assign frame_end = half_end && (half == HALF_LAST);
  assign quiet_end = (state == QUIET) && (qcnt == QUIET_LAST);

  assign ADC_sclk = ~((state == CONVERT) && half[0]);
  assign ADC_csn  = (state != CONVERT);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CONVERT;
      CONVERT: if (frame_end) state_nx = QUIET;
      QUIET: begin
        if (quiet_end)
          state_nx = continuous ? CONVERT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      half <= '0;
      qcnt <= '0;
    end else begin
      if (state == CONVERT) begin
        div <= half_end ? '0 : div + 1'b1;
        if (half_end)
          half <= frame_end ? '0 : half + 1'b1;
      end else begin
        div  <= '0;
        half <= '0;
      end
      if ((state == QUIET) && !quiet_end) qcnt <= qcnt + 1'b1;
      else                                qcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (rise) begin
      for (int i = 0; i < NCH; i++)
        shreg[i] <= (shreg[i] << 1) | FRAME_BITS'(ADC_sdata[i]);
    end
  end

  generate
    if (FRAME_BITS > DATA_W) begin : g_lead
      always_comb begin
        lead = '0;
        for (int i = 0; i < NCH; i++)
          lead[i] = |shreg[i][FRAME_BITS-1:DATA_W];
      end
    end else begin : g_nolead
      assign lead = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      frame_err  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= frame_end;
      if (frame_end) begin
        for (int i = 0; i < NCH; i++)
          data[i*DATA_W +: DATA_W] <= shreg[i][DATA_W-1:0];
        frame_err <= lead;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: scoreboard bench for adc_serial_capture.
// Instance a uses defaults; instance b is the 4-channel fast variant.
module tb_adc_serial_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic start_a = 1'b0, cont_a = 1'b0;
  logic [1:0] sdata_a;
  logic sclk_a, csn_a, dv_a, busy_a;
  logic [23:0] data_a;
  logic [1:0] ferr_a;

  logic start_b = 1'b0, cont_b = 1'b0;
  logic [3:0] sdata_b = 4'hF;
  logic sclk_b, csn_b, dv_b, busy_b;
  logic [47:0] data_b;
  logic [3:0] ferr_b;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int dva = 0;
  int dvb = 0;
  int rises_a = 0;
  int k_a = 0;

  logic [15:0] fr [2];

  typedef struct packed {
    logic [23:0] d;
    logic [1:0]  e;
  } exp_a_t;

  typedef struct packed {
    logic [47:0] d;
    logic [3:0]  e;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  adc_serial_capture u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .continuous(cont_a), .ADC_sdata(sdata_a),
    .ADC_sclk(sclk_a), .ADC_csn(csn_a),
    .data(data_a), .data_valid(dv_a),
    .frame_err(ferr_a), .busy(busy_a)
  );

  adc_serial_capture #(
    .NCH(4), .CLK_DIV(1), .QUIET_CYC(1)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .continuous(cont_b), .ADC_sdata(sdata_b),
    .ADC_sclk(sclk_b), .ADC_csn(csn_b),
    .data(data_b), .data_valid(dv_b),
    .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dv_a) dva++;
    if (dv_b) dvb++;
  end

  // ADC model: next bit presented after each rising sclk.
  always @(posedge sclk_a or posedge csn_a) begin
    if (csn_a) k_a = 0;
    else       k_a = k_a + 1;
  end

  always @(posedge sclk_a) if (!csn_a) rises_a++;

  always_comb begin
    for (int i = 0; i < 2; i++)
      sdata_a[i] = (k_a < 16) ? fr[i][4'(15 - k_a)] : 1'b0;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({csn_a, sclk_a, busy_a, dv_a, ferr_a, data_a} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 24'h0}) begin
      $display("FAIL reset_a: got %h", {csn_a, sclk_a, busy_a,
               dv_a, ferr_a, data_a});
    end else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({csn_a, sclk_a, busy_a, dv_a, ferr_a, data_a} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 24'h0}) begin
        $display("FAIL idle_a: got %h", {csn_a, sclk_a, busy_a,
                 dv_a, ferr_a, data_a});
      end else pass_cnt++;
    end
    chk_cnt++;
    if ({csn_b, sclk_b, busy_b, dv_b, ferr_b, data_b} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 48'h0}) begin
      $display("FAIL idle_b: got %h", {csn_b, sclk_b, busy_b,
               dv_b, ferr_b, data_b});
    end else pass_cnt++;
  endtask

  task automatic test_single();
    int low, n, b, r0;
    exp_a_t e;
    fr[0] = 16'h0A5C;
    fr[1] = 16'h0FFF;
    e.d = 24'hFFF_A5C;
    e.e = 2'b00;
    qa.push_back(e);
    r0 = rises_a;
    low = 0;
    n = 0;
    @(negedge clk) start_a = 1'b1;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      n++;
      if (!csn_a) low++;
    end while (!dv_a && n < 200);
    chk_cnt++;
    if (!dv_a) $display("FAIL single_dv: got 0 want 1");
    else pass_cnt++;
    chk_cnt++;
    if (low !== 66) $display("FAIL single_csn_low: got %0d want 66", low);
    else pass_cnt++;
    chk_cnt++;
    if (rises_a - r0 !== 16)
      $display("FAIL single_rises: got %0d want 16", rises_a - r0);
    else pass_cnt++;
    chk_cnt++;
    if (qa.size() == 0) $display("FAIL single_sb: got empty want entry");
    else begin
      e = qa.pop_front();
      if ({data_a, ferr_a} !== {e.d, e.e})
        $display("FAIL single_data: got %h want %h",
                 {data_a, ferr_a}, {e.d, e.e});
      else pass_cnt++;
    end
    b = 0;
    @(negedge clk);
    chk_cnt++;
    if (dv_a !== 1'b0) $display("FAIL single_dv_width: got 1 want 0");
    else pass_cnt++;
    while (busy_a && b < 20) begin
      b++;
      @(negedge clk);
    end
    chk_cnt++;
    if (b !== 3) $display("FAIL single_busy_tail: got %0d want 3", b);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int n;
    exp_a_t e;
    fr[0] = 16'h0456;
    fr[1] = 16'h8123;
    e.d = 24'h123_456;
    e.e = 2'b10;
    qa.push_back(e);
    n = 0;
    @(negedge clk) start_a = 1'b1;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      n++;
    end while (!dv_a && n < 200);
    chk_cnt++;
    if (!dv_a || qa.size() == 0) begin
      $display("FAIL ferr_dv: got dv=%b want 1", dv_a);
    end else begin
      e = qa.pop_front();
      if ({data_a, ferr_a} !== {e.d, e.e})
        $display("FAIL ferr_data: got %h want %h",
                 {data_a, ferr_a}, {e.d, e.e});
      else pass_cnt++;
    end
    n = 0;
    while (busy_a && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    int n, b, d0;
    logic [15:0] p0, p1;
    exp_a_t e;
    for (int j = 0; j < 6; j++) begin
      p0 = 16'(16'h0100 + 17 * j);
      p1 = 16'(16'h0A00 + 3 * j);
      e.d = {p1[11:0], p0[11:0]};
      e.e = 2'b00;
      qa.push_back(e);
    end
    fr[0] = 16'h0100;
    fr[1] = 16'h0A00;
    d0 = dva;
    cont_a = 1'b1;
    @(negedge clk) start_a = 1'b1;
    for (int j = 0; j < 6; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        start_a = (j == 2 && n == 20) || (j == 3 && n == 1) ||
                  (j == 5 && n == 40);
        if (j == 5 && n == 30) cont_a = 1'b0;
      end while (!dv_a && n < 200);
      chk_cnt++;
      if (!dv_a || qa.size() == 0) begin
        $display("FAIL cont_dv: frame %0d got none", j);
        break;
      end
      e = qa.pop_front();
      if ({data_a, ferr_a} !== {e.d, e.e})
        $display("FAIL cont_data: frame %0d got %h want %h",
                 j, {data_a, ferr_a}, {e.d, e.e});
      else pass_cnt++;
      if (j > 0) begin
        chk_cnt++;
        if (n !== 70)
          $display("FAIL cont_period: got %0d want 70", n);
        else pass_cnt++;
      end
      fr[0] = 16'(16'h0100 + 17 * (j + 1));
      fr[1] = 16'(16'h0A00 + 3 * (j + 1));
    end
    start_a = 1'b0;
    b = 0;
    @(negedge clk);
    while (busy_a && b < 20) begin
      b++;
      @(negedge clk);
    end
    chk_cnt++;
    if (b !== 3) $display("FAIL cont_busy_tail: got %0d want 3", b);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (dva - d0 !== 6)
      $display("FAIL cont_frames: got %0d want 6", dva - d0);
    else pass_cnt++;
    chk_cnt++;
    if ({csn_a, busy_a} !== 2'b10)
      $display("FAIL cont_idle: got %b want 10", {csn_a, busy_a});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int low, n, d0;
    exp_a_t e;
    fr[0] = 16'h0ABC;
    fr[1] = 16'h0DEF;
    d0 = dva;
    low = 0;
    n = 0;
    @(negedge clk) start_a = 1'b1;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      n++;
      if (!csn_a) low++;
    end while (low < 31 && n < 200);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({csn_a, sclk_a, busy_a, dv_a, data_a} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 24'h0})
      $display("FAIL rstmid_out: got %h want %h",
               {csn_a, sclk_a, busy_a, dv_a, data_a},
               {1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (dva !== d0) $display("FAIL rstmid_nodv: got %0d want %0d", dva, d0);
    else pass_cnt++;
    e.d = 24'hDEF_ABC;
    e.e = 2'b00;
    qa.push_back(e);
    low = 0;
    n = 0;
    @(negedge clk) start_a = 1'b1;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      n++;
      if (!csn_a) low++;
    end while (!dv_a && n < 200);
    chk_cnt++;
    if (low !== 66) $display("FAIL rstmid_low: got %0d want 66", low);
    else pass_cnt++;
    chk_cnt++;
    if (!dv_a || qa.size() == 0) begin
      $display("FAIL rstmid_dv: got dv=%b want 1", dv_a);
    end else begin
      e = qa.pop_front();
      if ({data_a, ferr_a} !== {e.d, e.e})
        $display("FAIL rstmid_data: got %h want %h",
                 {data_a, ferr_a}, {e.d, e.e});
      else pass_cnt++;
    end
    n = 0;
    while (busy_a && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_param();
    int low, n, b;
    exp_b_t e;
    for (int j = 0; j < 3; j++) begin
      e.d = 48'hFFF_FFF_FFF_FFF;
      e.e = 4'hF;
      qb.push_back(e);
    end
    cont_b = 1'b1;
    @(negedge clk) start_b = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      low = 0;
      do begin
        @(negedge clk);
        start_b = 1'b0;
        n++;
        if (!csn_b) low++;
        if (j == 2 && n == 5) cont_b = 1'b0;
      end while (!dv_b && n < 200);
      chk_cnt++;
      if (!dv_b || qb.size() == 0) begin
        $display("FAIL param_dv: frame %0d got none", j);
        break;
      end
      e = qb.pop_front();
      if ({data_b, ferr_b} !== {e.d, e.e})
        $display("FAIL param_data: got %h want %h",
                 {data_b, ferr_b}, {e.d, e.e});
      else pass_cnt++;
      chk_cnt++;
      if (low !== 33) $display("FAIL param_low: got %0d want 33", low);
      else pass_cnt++;
      if (j > 0) begin
        chk_cnt++;
        if (n !== 34) $display("FAIL param_period: got %0d want 34", n);
        else pass_cnt++;
      end
    end
    b = 0;
    @(negedge clk);
    while (busy_b && b < 20) begin
      b++;
      @(negedge clk);
    end
    chk_cnt++;
    if (b !== 0) $display("FAIL param_busy_tail: got %0d want 0", b);
    else pass_cnt++;
  endtask

  initial begin
    fr[0] = 16'h0;
    fr[1] = 16'h0;
    #1;
    test_reset();
    test_single();
    test_frame_err();
    test_continuous();
    test_reset_mid();
    test_param();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adc_serial_capture.md
# adc_serial_capture

Parametrised serial-ADC capture engine for AD7476A-class converters, such as the dual-channel Pmod AD1. It generates one shared chip-select and serial clock, and shifts in NCH data lines in parallel. Each conversion yields one NCH×DATA_W result word, a valid strobe and per-channel framing-error flags. It adds single-shot or continuous conversion, programmable serial-clock rate and programmable inter-frame quiet time. It sits between the ADC pins and the sample FIFO / FFT front end, in the fabric clock domain.

## Interface
- NCH, 2, number of ADC data lines captured in parallel (≥1)
- DATA_W, 12, result bits per channel; the LSBs of each frame (≥1)
- FRAME_BITS, 16, serial clocks per frame (≥DATA_W); the upper FRAME_BITS−DATA_W bits are leading zeros
- CLK_DIV, 2, clk cycles per ADC_sclk half-period (≥1)
- QUIET_CYC, 4, clk cycles ADC_csn is held high between frames (≥1)
- clk  in  1  fabric clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin conversion; ignored while busy
- continuous  in  1  1 = re-arm automatically after each frame
- ADC_sdata  in  NCH  serial data from the ADC, MSB first
- ADC_sclk  out  1  serial clock to the ADC; idles high
- ADC_csn  out  1  active-low chip select shared by all channels
- data  out  NCH*DATA_W  channel i occupies data[i*DATA_W +: DATA_W]
- data_valid  out  1  one-cycle strobe; data and frame_err are new
- frame_err  out  NCH  bit i = a leading bit of channel i's last frame was nonzero
- busy  out  1  high from the first ADC_csn-low cycle until return to IDLE

## Operation
- States: IDLE, CONVERT, QUIET.
- **IDLE**
  - ADC_csn=1, ADC_sclk=1, busy=0.
  - start=1 → CONVERT on the next edge.
- **CONVERT**
  - Cycle 0 is the first cycle with ADC_csn=0. busy=1.
  - A half-period counter divides clk by CLK_DIV. ADC_sclk stays high for cycles 0..CLK_DIV−1, then toggles every CLK_DIV cycles.
  - This gives exactly FRAME_BITS low/high pairs. ADC_sclk ends high.
  - On each clk edge that drives ADC_sclk 0→1, ADC_sdata[i] is shifted into channel i's FRAME_BITS-bit shift register, MSB first. There is no input synchroniser.
  - After the FRAME_BITS-th rising sclk edge, go to QUIET.
- **QUIET**
  - In its first cycle, cycle T=(2·FRAME_BITS+1)·CLK_DIV: ADC_csn=1 and data_valid=1.
  - data[i] = low DATA_W bits of shift register i.
  - frame_err[i] = OR of the upper FRAME_BITS−DATA_W bits of shift register i (always 0 when FRAME_BITS=DATA_W).
  - Stay in QUIET for QUIET_CYC cycles.
  - At the last QUIET cycle, sample continuous: 1 → CONVERT, 0 → IDLE.
- start is ignored outside IDLE. Dropping continuous never truncates a frame in progress.
- data and frame_err hold their values until the next data_valid.

## Timing
- **Reset values** (asynchronous, immediate): ADC_csn=1, ADC_sclk=1, data=0, frame_err=0, data_valid=0, busy=0, state=IDLE, all counters 0.
- **Reset mid-frame:** the frame is abandoned, no data_valid is issued, and data is cleared to 0.
- **start latency:** ADC_csn falls in the cycle after start is sampled high.
- **Frame latency:** data_valid occurs T cycles after ADC_csn falls. Defaults: T=66.
- **ADC_csn low time:** exactly T cycles per frame.
- **Continuous period:** T+QUIET_CYC cycles. Defaults: 70 (500 kS/s at 35 MHz).
- **busy:** falls in the cycle after the last QUIET cycle when returning to IDLE. In continuous mode it stays high.
- **start and continuous asserted together from IDLE:** continuous mode begins; start is not queued.

## Test plan
- **Reset:** hold rst, then release; toggle start=0 → ADC_csn=1, ADC_sclk=1, data=0, data_valid=0, busy=0, frame_err=0 throughout.
- **Single shot, defaults:** ch0 drives frame 0x0A5C, ch1 drives 0x0FFF, one start pulse.
  - Exactly 16 ADC_sclk rising edges; ADC_csn low 66 cycles.
  - data_valid one cycle at cycle 66 with data=24'hFFF_A5C, frame_err=2'b00.
  - busy low 4 cycles after data_valid.
- **Framing error:** ch1 drives frame 0x8123 → data[23:12]=12'h123, frame_err=2'b10.
- **Continuous:** continuous=1 plus a start pulse → data_valid every 70 cycles for ≥5 frames.
  - Clear continuous mid-frame → that frame completes with data_valid, then IDLE, busy=0.
  - start pulses while busy cause no extra frames.
- **Reset mid-frame:** assert rst at cycle 30 of CONVERT → ADC_csn=1 and ADC_sclk=1 immediately, no data_valid, data=0. A later start produces a correct full frame.
- **Parametric:** NCH=4, CLK_DIV=1, QUIET_CYC=1, ADC_sdata=4'hF constant.
  - ADC_csn low 33 cycles; period 34 cycles.
  - data=48'hFFF_FFF_FFF_FFF, frame_err=4'hF.
